// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared ALU op, flag index, branch condition and flag command codes
package proc_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_LDD = 3'b011;
  localparam logic [2:0] ALU_STD = 3'b100;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;

  localparam logic [1:0] BR_JMP = 2'b00;
  localparam logic [1:0] BR_JZ  = 2'b01;
  localparam logic [1:0] BR_JN  = 2'b10;
  localparam logic [1:0] BR_JC  = 2'b11;

  localparam logic [1:0] FCMD_NONE = 2'b00;
  localparam logic [1:0] FCMD_SETC = 2'b01;
  localparam logic [1:0] FCMD_CLRC = 2'b10;
  localparam logic [1:0] FCMD_RSVD = 2'b11;

endpackage

// File: rtl/ccr_branch_unit_if.sv
// rtl/ccr_branch_unit_if.sv - EX-stage flag, branch and interrupt signals of the CCR unit
interface ccr_branch_unit_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
);

  logic              stall;
  logic              flush;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic [1:0]        flag_cmd;
  logic              br_valid;
  logic [1:0]        br_cond;
  logic              int_save;
  logic              rti_restore;
  logic [2:0]        ccr;
  logic              br_taken;
  logic              shadow_valid;
  logic              ccr_err;

  modport master (
    output stall, flush, alu_op, alu_out, alu_carry, flag_cmd,
           br_valid, br_cond, int_save, rti_restore,
    input  ccr, br_taken, shadow_valid, ccr_err
  );

  modport slave (
    input  stall, flush, alu_op, alu_out, alu_carry, flag_cmd,
           br_valid, br_cond, int_save, rti_restore,
    output ccr, br_taken, shadow_valid, ccr_err
  );

endinterface

// File: rtl/ccr_branch_unit_flag_gen.sv
// rtl/ccr_branch_unit_flag_gen.sv - combinational forwarded-flag derivation from the EX result
module ccr_branch_unit_flag_gen
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic [1:0]        flag_cmd,
  input  logic              flush,
  input  logic [2:0]        ccr,
  output logic [2:0]        f
);

  always_comb begin
    f = ccr;
    // A flushed instruction contributes no ALU flags, but the explicit flag command survives.
    if (!flush) begin
      if (alu_op == OP_W'(ALU_ADD)) begin
        f[FLG_Z] = (alu_out == '0);
        f[FLG_C] = alu_carry;
        f[FLG_N] = alu_out[DATA_W-1];
      end else if (alu_op == OP_W'(ALU_NOT)) begin
        f[FLG_Z] = (alu_out == '0);
        f[FLG_N] = alu_out[DATA_W-1];
      end
    end
    case (flag_cmd)
      FCMD_SETC: f[FLG_C] = 1'b1;
      FCMD_CLRC: f[FLG_C] = 1'b0;
      default:   ;
    endcase
  end

endmodule

// File: rtl/ccr_branch_unit.sv
// rtl/ccr_branch_unit.sv - CCR register, same-cycle branch resolve with flag consume, interrupt shadow
module ccr_branch_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  ccr_branch_unit_if.slave    bus
);

  logic [2:0] ccr_q;
  logic [2:0] shadow_q;
  logic       shadow_valid_q;
  logic       err_q;
  logic [2:0] f;
  logic       cond;
  logic       taken;
  logic [2:0] ccr_nxt;

  ccr_branch_unit_flag_gen #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_flag_gen (
    .alu_op    (bus.alu_op),
    .alu_out   (bus.alu_out),
    .alu_carry (bus.alu_carry),
    .flag_cmd  (bus.flag_cmd),
    .flush     (bus.flush),
    .ccr       (ccr_q),
    .f         (f)
  );

  always_comb begin
    cond = 1'b0;
    case (bus.br_cond)
      BR_JMP:  cond = 1'b1;
      BR_JZ:   cond = f[FLG_Z];
      BR_JN:   cond = f[FLG_N];
      BR_JC:   cond = f[FLG_C];
      default: cond = 1'b0;
    endcase
  end

  assign taken = rst_n & bus.br_valid & ~bus.stall & ~bus.flush & cond;

  // A taken conditional branch consumes the flag it tested.
  always_comb begin
    ccr_nxt = f;
    if (taken) begin
      case (bus.br_cond)
        BR_JZ:   ccr_nxt[FLG_Z] = 1'b0;
        BR_JN:   ccr_nxt[FLG_N] = 1'b0;
        BR_JC:   ccr_nxt[FLG_C] = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ccr_q          <= '0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.rti_restore) begin
        ccr_q          <= shadow_q;
        shadow_valid_q <= 1'b0;
        if (!shadow_valid_q || bus.int_save) begin
          err_q <= 1'b1;
        end
      end else begin
        ccr_q <= ccr_nxt;
        if (bus.int_save) begin
          shadow_q       <= ccr_q;
          shadow_valid_q <= 1'b1;
          if (shadow_valid_q) begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ccr          = ccr_q;
  assign bus.br_taken     = taken;
  assign bus.shadow_valid = shadow_valid_q;
  assign bus.ccr_err      = err_q;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// tb/tb_ccr_branch_unit.sv - directed vector bench for ccr_branch_unit
module tb_ccr_branch_unit;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ccr_branch_unit_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  ccr_branch_unit #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [2:0]  op;
    logic [15:0] out;
    logic        carry;
    logic [1:0]  cmd;
    logic        bv;
    logic [1:0]  bc;
    logic        save;
    logic        rti;
    logic        e_br;
    logic [2:0]  e_ccr;
    logic        e_sv;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic st, input logic fl, input logic [2:0] op,
                     input logic [15:0] out, input logic c, input logic [1:0] cmd,
                     input logic bv, input logic [1:0] bc, input logic sv_in, input logic rti,
                     input logic e_br, input logic [2:0] e_ccr, input logic e_sv, input logic e_err);
    vec_t v;
    v = '{r, st, fl, op, out, c, cmd, bv, bc, sv_in, rti, e_br, e_ccr, e_sv, e_err};
    vq.push_back(v);
  endtask

  task automatic check1(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n           = v.rst_n;
    bus.stall       = v.stall;
    bus.flush       = v.flush;
    bus.alu_op      = v.op;
    bus.alu_out     = v.out;
    bus.alu_carry   = v.carry;
    bus.flag_cmd    = v.cmd;
    bus.br_valid    = v.bv;
    bus.br_cond     = v.bc;
    bus.int_save    = v.save;
    bus.rti_restore = v.rti;
  endtask

  task automatic idle();
    vec_t v;
    v = '{1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0,
          1'b0, 3'd0, 1'b0, 1'b0};
    drive(v);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    rst_n = 1'b0;

    //  rst st fl op    out      c  cmd   bv bc    sv rti   br ccr     sv err
    add(0, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 1, 2'd0, 0, 0,   0, 3'b000, 0, 0);
    add(1, 0, 0, 3'd1, 16'h0000, 1, 2'd0, 0, 2'd0, 0, 0,   0, 3'b011, 0, 0);
    add(1, 0, 0, 3'd1, 16'h8001, 0, 2'd0, 0, 2'd0, 0, 0,   0, 3'b100, 0, 0);
    add(1, 0, 0, 3'd2, 16'h0000, 1, 2'd0, 1, 2'd1, 0, 0,   1, 3'b000, 0, 0);
    add(1, 0, 0, 3'd1, 16'h0001, 1, 2'd0, 0, 2'd0, 0, 0,   0, 3'b010, 0, 0);
    add(1, 1, 0, 3'd0, 16'h0000, 0, 2'd0, 1, 2'd3, 0, 0,   0, 3'b010, 0, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 1, 2'd3, 0, 0,   1, 3'b000, 0, 0);
    add(1, 0, 0, 3'd1, 16'h8000, 1, 2'd0, 0, 2'd0, 0, 0,   0, 3'b110, 0, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 1, 2'd0, 0, 0,   1, 3'b110, 0, 0);
    add(1, 0, 0, 3'd3, 16'h0000, 0, 2'd0, 1, 2'd2, 0, 0,   1, 3'b010, 0, 0);
    add(1, 0, 0, 3'd1, 16'h8000, 1, 2'd0, 0, 2'd0, 0, 0,   0, 3'b110, 0, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 1, 0,   0, 3'b110, 1, 0);
    add(1, 0, 0, 3'd1, 16'h0005, 1, 2'd0, 0, 2'd0, 0, 0,   0, 3'b010, 1, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 0, 1,   0, 3'b110, 0, 0);
    add(1, 0, 0, 3'd4, 16'h0000, 0, 2'd0, 1, 2'd1, 0, 0,   0, 3'b110, 0, 0);
    add(1, 0, 0, 3'd1, 16'h0002, 0, 2'd1, 0, 2'd0, 0, 0,   0, 3'b010, 0, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd2, 0, 2'd0, 0, 0,   0, 3'b000, 0, 0);
    add(1, 0, 0, 3'd1, 16'h0003, 1, 2'd3, 0, 2'd0, 0, 0,   0, 3'b010, 0, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd2, 0, 2'd0, 0, 0,   0, 3'b000, 0, 0);
    add(1, 0, 1, 3'd1, 16'h0000, 0, 2'd1, 1, 2'd1, 0, 0,   0, 3'b010, 0, 0);
    add(1, 0, 1, 3'd0, 16'h0000, 0, 2'd0, 1, 2'd3, 0, 0,   0, 3'b010, 0, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 0, 1,   0, 3'b110, 0, 1);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 1, 0,   0, 3'b110, 1, 1);
    add(1, 0, 0, 3'd1, 16'h0001, 0, 2'd0, 0, 2'd0, 1, 0,   0, 3'b000, 1, 1);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 1, 1,   0, 3'b110, 0, 1);
    add(1, 0, 0, 3'd1, 16'h0001, 0, 2'd0, 0, 2'd0, 0, 0,   0, 3'b000, 0, 1);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 0, 1,   0, 3'b110, 0, 1);
    add(0, 0, 0, 3'd1, 16'h0000, 1, 2'd1, 1, 2'd0, 1, 0,   0, 3'b000, 0, 0);
    add(1, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 0, 1,   0, 3'b000, 0, 1);
    add(0, 0, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 0, 0,   0, 3'b000, 0, 0);
    add(1, 1, 0, 3'd1, 16'h0001, 1, 2'd0, 0, 2'd0, 1, 0,   0, 3'b000, 0, 0);
    add(1, 1, 0, 3'd0, 16'h0000, 0, 2'd0, 0, 2'd0, 0, 1,   0, 3'b000, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      check1("br_taken", i, {2'b00, bus.br_taken}, {2'b00, vq[i].e_br});
      @(posedge clk);
      #1;
      check1("ccr", i, bus.ccr, vq[i].e_ccr);
      check1("shadow_valid", i, {2'b00, bus.shadow_valid}, {2'b00, vq[i].e_sv});
      check1("ccr_err", i, {2'b00, bus.ccr_err}, {2'b00, vq[i].e_err});
      @(negedge clk);
    end

    // Multi-cycle stall: a pending ADD and branch must be held off until release.
    idle();
    bus.stall     = 1'b1;
    bus.alu_op    = 3'd1;
    bus.alu_out   = 16'h0000;
    bus.alu_carry = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_cond   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check1("stall_br", 100 + k, {2'b00, bus.br_taken}, 3'b000);
      @(posedge clk);
      #1;
      check1("stall_ccr", 100 + k, bus.ccr, 3'b000);
      @(negedge clk);
    end
    bus.stall = 1'b0;
    #1;
    check1("release_br", 103, {2'b00, bus.br_taken}, 3'b001);
    @(posedge clk);
    #1;
    check1("release_ccr", 103, bus.ccr, 3'b011);
    @(negedge clk);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
